// File: rtl/ddr_frame_reader_pkg.sv
// Shared constants, FSM state type and word-unpacking helpers for the DDR2 frame reader.
package ddr_frame_reader_pkg;

  // Frame layout shared with the frame loader: one pixel byte per 32-bit lane.
  localparam logic [27:0] DdrBaseAddr  = 28'h3000000;
  localparam int unsigned DdrWordCount = 38400;
  localparam int unsigned DdrAddrStep  = 8;
  localparam int unsigned DdrFifoDepth = 4;
  localparam int unsigned Lanes        = 8;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDrain} state_e;

  // Low byte of each 32-bit lane becomes one pixel.
  function automatic logic [63:0] unpack_pixels(logic [255:0] word);
    logic [63:0] pix;
    pix = '0;
    for (int i = 0; i < Lanes; i++) begin
      pix[8*i +: 8] = word[32*i +: 8];
    end
    return pix;
  endfunction

  // Any nonzero bit above a lane's pixel byte means the frame was not stored as expected.
  function automatic logic lane_fmt_err(logic [255:0] word);
    logic err;
    err = 1'b0;
    for (int i = 0; i < Lanes; i++) begin
      err = err | (|word[32*i+8 +: 24]);
    end
    return err;
  endfunction

endpackage

// File: rtl/ddr_frame_reader_if.sv
// Memory data-port command/response signals plus the pixel output stream.
interface ddr_frame_reader_if;
  logic [27:0]  mem_data_addr1;
  logic         mem_rw_data1;
  logic         mem_valid_data1;
  logic         mem_ready_data1;
  logic [255:0] mem_data_rd1;
  logic [255:0] mem_data_wr1;
  logic [63:0]  pix_data;
  logic         pix_valid;
  logic         pix_ready;

  // Reader side: issues commands, produces pixels.
  modport master (
    output mem_data_addr1, mem_rw_data1, mem_valid_data1, mem_data_wr1, pix_data, pix_valid,
    input  mem_ready_data1, mem_data_rd1, pix_ready
  );

  // Memory and consumer side.
  modport slave (
    input  mem_data_addr1, mem_rw_data1, mem_valid_data1, mem_data_wr1, pix_data, pix_valid,
    output mem_ready_data1, mem_data_rd1, pix_ready
  );
endinterface

// File: rtl/ddr_frame_reader_sync_fifo.sv
// Small synchronous FIFO; head reads as zero while empty.
module ddr_frame_reader_sync_fifo #(
  parameter int unsigned Width = 64,
  parameter int unsigned Depth = 4,
  localparam int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [Width-1:0] data_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AddrW:0]   count_o
);

  localparam logic [AddrW-1:0] PtrOne   = 1;
  localparam logic [AddrW:0]   CntOne   = 1;
  localparam logic [AddrW:0]   CntDepth = (AddrW+1)'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AddrW:0]   cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Occupancy changes only when exactly one of push/pop happens.
  always_comb begin
    cnt_d = cnt_q;
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + CntOne;
    end else if (!do_push && do_pop) begin
      cnt_d = cnt_q - CntOne;
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
      cnt_q <= cnt_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign full_o  = (cnt_q == CntDepth);
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/ddr_frame_reader.sv
// Reads a frame back from DDR2 one 256-bit word at a time and streams 8-pixel beats.
module ddr_frame_reader
  import ddr_frame_reader_pkg::*;
#(
  parameter logic [27:0] BaseAddr  = DdrBaseAddr,
  parameter int unsigned WordCount = DdrWordCount,
  parameter int unsigned AddrStep  = DdrAddrStep,
  parameter int unsigned FifoDepth = DdrFifoDepth
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      start_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      fmt_err_o,
  ddr_frame_reader_if.master        bus_io
);

  localparam int unsigned CntW       = $clog2(FifoDepth) + 1;
  localparam logic [15:0] WordCountW = 16'(WordCount);
  localparam logic [27:0] AddrStepW  = 28'(AddrStep);

  state_e        state_q, state_d;
  logic [27:0]   addr_q, addr_d;
  logic [15:0]   word_cnt_q, word_cnt_d;
  logic          valid_q, valid_d;
  logic          busy_q, busy_d;
  logic          fmt_err_q, fmt_err_d;
  logic          done;

  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CntW-1:0] fifo_cnt;
  logic [63:0]   fifo_head;

  assign fifo_pop = !fifo_empty && bus_io.pix_ready;

  // Next-state and command control; only one read is ever outstanding.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    word_cnt_d = word_cnt_q;
    valid_d    = valid_q;
    busy_d     = busy_q;
    fmt_err_d  = fmt_err_q;
    fifo_push  = 1'b0;
    done       = 1'b0;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d    = StIssue;
          busy_d     = 1'b1;
          addr_d     = BaseAddr;
          word_cnt_d = '0;
          fmt_err_d  = 1'b0;
        end
      end
      StIssue: begin
        // A pop this cycle frees the slot the response will land in.
        if (!fifo_full || fifo_pop) begin
          valid_d = 1'b1;
          state_d = StWait;
        end
      end
      StWait: begin
        if (bus_io.mem_ready_data1) begin
          fifo_push  = 1'b1;
          valid_d    = 1'b0;
          addr_d     = addr_q + AddrStepW;
          word_cnt_d = word_cnt_q + 16'd1;
          fmt_err_d  = fmt_err_q | lane_fmt_err(bus_io.mem_data_rd1);
          state_d    = (word_cnt_d == WordCountW) ? StDrain : StIssue;
        end
      end
      StDrain: begin
        if (fifo_cnt == '0) begin
          done    = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      addr_q     <= BaseAddr;
      word_cnt_q <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      fmt_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      word_cnt_q <= word_cnt_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      fmt_err_q  <= fmt_err_d;
    end
  end

  ddr_frame_reader_sync_fifo #(
    .Width (64),
    .Depth (FifoDepth)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .data_i  (unpack_pixels(bus_io.mem_data_rd1)),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  assign bus_io.mem_data_addr1  = addr_q;
  assign bus_io.mem_rw_data1    = 1'b0;
  assign bus_io.mem_valid_data1 = valid_q;
  assign bus_io.mem_data_wr1    = '0;
  assign bus_io.pix_data        = fifo_head;
  assign bus_io.pix_valid       = !fifo_empty;

  assign busy_o    = busy_q;
  assign done_o    = done;
  assign fmt_err_o = fmt_err_q;

endmodule

// File: tb/tb_ddr_frame_reader.sv
// Randomized bench for ddr_frame_reader with a transaction-level reference model.
module tb_ddr_frame_reader;

  localparam int unsigned WC    = 6;
  localparam int unsigned Depth = 4;
  localparam logic [27:0] TbBase = 28'h3000000;

  logic clk, rst_n, start, busy, done, fmt_err;
  ddr_frame_reader_if bus ();

  ddr_frame_reader #(
    .WordCount (WC),
    .FifoDepth (Depth)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .start_i   (start),
    .busy_o    (busy),
    .done_o    (done),
    .fmt_err_o (fmt_err),
    .bus_io    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  logic [63:0] exp_q [$];
  logic [27:0] cmd_log [$];
  logic [63:0] pop_log [$];
  bit          m_busy, m_fmt, m_pending, m_expect_valid, prev_valid, prev_hit, frame_done;
  int          m_words, wait_left, pops;
  logic [27:0] prev_addr;

  // Stimulus knobs.
  int          lat_min, lat_max, pr_pct, start_pct, noise_pct, bad_pct;
  bit          start_req, fixed_en;
  logic [255:0] fixed_word;

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [255:0] make_word();
    logic [255:0] w;
    if (fixed_en) return fixed_word;
    for (int i = 0; i < 8; i++) begin
      w[32*i +: 8]  = 8'($urandom_range(255));
      w[32*i+8 +: 24] = ($urandom_range(99) < bad_pct) ? 24'($urandom_range(24'hFFFFFF, 1)) : 24'h0;
    end
    return w;
  endfunction

  function automatic logic [63:0] pixels_of(logic [255:0] w);
    logic [63:0] p;
    for (int i = 0; i < 8; i++) p[8*i +: 8] = w[32*i +: 8];
    return p;
  endfunction

  function automatic bit has_fmt_err(logic [255:0] w);
    bit e = 0;
    for (int i = 0; i < 8; i++) if (w[32*i+8 +: 24] != 24'h0) e = 1;
    return e;
  endfunction

  task automatic clear_model();
    exp_q.delete();
    cmd_log.delete();
    pop_log.delete();
    m_busy = 0; m_fmt = 0; m_pending = 0; m_expect_valid = 0;
    prev_valid = 0; prev_hit = 0; m_words = 0; wait_left = -1; pops = 0;
    prev_addr = TbBase;
  endtask

  // One clock: compare outputs, drive next inputs, advance the model.
  task automatic cycle();
    logic [255:0] w;
    bit cur_valid, hit, pop, room, pr, exp_done;
    int qs;
    @(negedge clk);
    cur_valid = bus.mem_valid_data1;
    qs = exp_q.size();
    exp_done = m_busy && (m_words == WC) && (qs == 0);
    chk("busy", 256'(busy), 256'(m_busy));
    chk("fmt_err", 256'(fmt_err), 256'(m_fmt));
    chk("done", 256'(done), 256'(exp_done));
    chk("pix_valid", 256'(bus.pix_valid), 256'(qs != 0));
    if (bus.pix_valid && qs != 0) chk("pix_data", 256'(bus.pix_data), 256'(exp_q[0]));
    if (prev_valid && !prev_hit) begin
      chk("valid_hold", 256'(cur_valid), 256'(1));
      chk("addr_hold", 256'(bus.mem_data_addr1), 256'(prev_addr));
    end else begin
      chk("valid_issue", 256'(cur_valid), 256'(m_expect_valid));
    end
    if (cur_valid) chk("addr", 256'(bus.mem_data_addr1), 256'(TbBase + 28'(8 * m_words)));
    chk("occupancy", 256'((qs + int'(cur_valid)) <= Depth), 256'(1));
    chk("rw_wr", {255'(bus.mem_data_wr1 != '0), bus.mem_rw_data1}, 256'(0));
    m_expect_valid = 0;

    // Drive inputs for the next edge.
    start = start_req || ($urandom_range(99) < start_pct);
    start_req = 0;
    pr = ($urandom_range(99) < pr_pct);
    bus.pix_ready = pr;
    hit = 0;
    if (cur_valid) begin
      if (wait_left < 0) wait_left = $urandom_range(lat_max, lat_min);
      if (wait_left == 0) hit = 1;
      else wait_left--;
    end
    w = make_word();
    if (hit) begin
      bus.mem_ready_data1 = 1'b1;
      bus.mem_data_rd1    = w;
    end else if (!cur_valid && $urandom_range(99) < noise_pct) begin
      bus.mem_ready_data1 = 1'b1;
      bus.mem_data_rd1    = {$urandom, $urandom, $urandom, $urandom,
                             $urandom, $urandom, $urandom, $urandom};
    end else begin
      bus.mem_ready_data1 = 1'b0;
    end

    // Model update.
    pop  = (qs != 0) && pr;
    room = (qs < Depth) || pop;
    if (m_pending && room) begin
      m_expect_valid = 1;
      m_pending = 0;
    end
    if (pop) begin
      pop_log.push_back(bus.pix_data);
      void'(exp_q.pop_front());
      pops++;
    end
    if (hit) begin
      exp_q.push_back(pixels_of(w));
      cmd_log.push_back(bus.mem_data_addr1);
      m_words++;
      if (has_fmt_err(w)) m_fmt = 1;
      if (m_words != WC) m_pending = 1;
      wait_left = -1;
    end
    if (exp_done) begin
      m_busy = 0;
      frame_done = 1;
    end else if (start && !m_busy) begin
      m_busy = 1; m_fmt = 0; m_words = 0; m_pending = 1; pops = 0;
      cmd_log.delete();
      pop_log.delete();
    end
    prev_valid = cur_valid;
    prev_hit   = hit;
    prev_addr  = bus.mem_data_addr1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b0;
    bus.mem_ready_data1 = 1'b0;
    bus.pix_ready = 1'b0;
    #1;
    chk("rst_valid", 256'(bus.mem_valid_data1), 256'(0));
    chk("rst_addr", 256'(bus.mem_data_addr1), 256'(28'h3000000));
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_done", 256'(done), 256'(0));
    chk("rst_fmt_err", 256'(fmt_err), 256'(0));
    chk("rst_pix_valid", 256'(bus.pix_valid), 256'(0));
    chk("rst_pix_data", 256'(bus.pix_data), 256'(0));
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic launch();
    frame_done = 0;
    start_req  = 1;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && !frame_done; i++) cycle();
    chk("frame_done_timeout", 256'(frame_done), 256'(1));
    chk("beats_per_frame", 256'(pops), 256'(WC));
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    bus.mem_ready_data1 = 1'b0;
    bus.mem_data_rd1 = '0;
    bus.pix_ready = 1'b0;
    lat_min = 1; lat_max = 1; pr_pct = 100; start_pct = 0; noise_pct = 0; bad_pct = 0;
    start_req = 0; frame_done = 0;
    fixed_en = 1;
    fixed_word = 256'h00000088_00000077_00000066_00000055_00000044_00000033_00000022_00000011;
    clear_model();
    do_reset();

    // Fixed lane pattern, ready one cycle after valid.
    launch();
    wait_done(200);
    chk("first_addr", 256'(cmd_log.size() > 0 ? cmd_log[0] : 28'hFFFFFFF), 256'(28'h3000000));
    chk("second_addr", 256'(cmd_log.size() > 1 ? cmd_log[1] : 28'hFFFFFFF), 256'(28'h3000008));
    chk("first_beat", 256'(pop_log.size() > 0 ? pop_log[0] : 64'h0), 256'(64'h8877665544332211));
    chk("fmt_clean", 256'(fmt_err), 256'(0));

    // Slow memory: ready five cycles after valid.
    fixed_en = 0; lat_min = 5; lat_max = 5;
    launch();
    wait_done(400);

    // Consumer stalled: only as many commands as FIFO slots.
    lat_min = 1; lat_max = 1; pr_pct = 0;
    launch();
    for (int i = 0; i < 40; i++) cycle();
    chk("bp_cmds", 256'(m_words), 256'(Depth));
    chk("bp_valid_low", 256'(bus.mem_valid_data1), 256'(0));
    pr_pct = 100;
    wait_done(200);

    // Nonzero upper bits in lane 3.
    fixed_en = 1;
    fixed_word = 256'h00000088_00000077_00000066_00000055_00000100_00000033_00000022_00000011;
    launch();
    wait_done(200);
    cycle();
    chk("fmt_sticky", 256'(fmt_err), 256'(1));
    fixed_en = 0;
    launch();
    cycle();
    cycle();
    chk("fmt_cleared", 256'(fmt_err), 256'(0));
    wait_done(200);

    // Reset while a command is outstanding, then reread from the base.
    lat_min = 5; lat_max = 5;
    launch();
    for (int i = 0; i < 20 && !bus.mem_valid_data1; i++) cycle();
    cycle();
    cycle();
    chk("in_wait", 256'(bus.mem_valid_data1), 256'(1));
    do_reset();
    lat_min = 1; lat_max = 2;
    launch();
    wait_done(300);
    chk("reread_addr", 256'(cmd_log.size() > 0 ? cmd_log[0] : 28'hFFFFFFF), 256'(28'h3000000));

    // Random latency, backpressure, stray starts and stray ready pulses.
    lat_min = 1; lat_max = 4; pr_pct = 70; start_pct = 20; noise_pct = 30; bad_pct = 3;
    for (int f = 0; f < 4; f++) begin
      launch();
      wait_done(600);
    end
    start_pct = 0;
    for (int i = 0; i < 5; i++) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
